// File: rtl/sha_state_bank.sv
// sha_state_bank: working-state register bank for the SHA-256 core.
// Holds NUM_WORDS words and supports these commands:
//   - single-word WRITE
//   - parallel LOAD
//   - modular ACCUM (final hash add)
//   - handshaked serial DUMP of all words
// Optional feature macro: STATE_BANK_ACCUM_EN.
//   Defined:   ACCUM adds in_state_i into the bank, word by word.
//   Undefined: no adders are built and cmd 3 acts as HOLD.
module sha_state_bank #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 8,
   parameter int ADDR_W    = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [2:0]                    cmd_i,
   input  logic                          cmd_valid_i,
   output logic                          cmd_ready_o,
   input  logic [ADDR_W-1:0]             addr_i,
   input  logic [WORD_W-1:0]             in_var_i,
   input  logic [NUM_WORDS*WORD_W-1:0]   in_state_i,
   output logic [NUM_WORDS*WORD_W-1:0]   out_state_o,
   output logic                          addr_err_o,
   output logic [WORD_W-1:0]             dump_data_o,
   output logic                          dump_valid_o,
   input  logic                          dump_ready_i,
   output logic                          dump_last_o
);

   localparam logic [2:0] CMD_WRITE = 3'd1;
   localparam logic [2:0] CMD_LOAD  = 3'd2;
   localparam logic [2:0] CMD_ACCUM = 3'd3;
   localparam logic [2:0] CMD_DUMP  = 3'd4;

   typedef enum logic {S_IDLE, S_DUMP} state_t;

   state_t                             state_q, state_d;
   logic [NUM_WORDS-1:0][WORD_W-1:0]   words_q, words_d;
   logic [ADDR_W-1:0]                  idx_q, idx_d;
   logic [WORD_W-1:0]                  dump_data_q, dump_data_d;
   logic                               addr_err_q, addr_err_d;
   logic                               addr_ok;
   logic                               idx_last;

   assign addr_ok  = (32'(addr_i) < 32'(NUM_WORDS));
   assign idx_last = (idx_q == ADDR_W'(NUM_WORDS - 1));

   // Packed word array already matches the word-i-at-[i*WORD_W] layout.
   assign out_state_o = words_q;
   assign addr_err_o  = addr_err_q;
   assign dump_data_o = dump_data_q;
   assign dump_last_o = (state_q == S_DUMP) && idx_last;

   // State register: everything returns to zero/IDLE on reset, even mid-dump.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         words_q     <= '0;
         idx_q       <= '0;
         dump_data_q <= '0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         words_q     <= words_d;
         idx_q       <= idx_d;
         dump_data_q <= dump_data_d;
         addr_err_q  <= addr_err_d;
      end
   end

   // Next state: commands are decoded only in IDLE. DUMP freezes the bank and
   // walks idx. dump_data is loaded one cycle ahead so it is stable while stalled.
   always_comb begin
      state_d      = state_q;
      words_d      = words_q;
      idx_d        = idx_q;
      dump_data_d  = dump_data_q;
      addr_err_d   = 1'b0;
      cmd_ready_o  = 1'b0;
      dump_valid_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               case (cmd_i)
                  CMD_WRITE: begin
                     if (addr_ok) begin
                        for (int i = 0; i < NUM_WORDS; i++)
                           if (ADDR_W'(i) == addr_i) words_d[i] = in_var_i;
                     end else begin
                        addr_err_d = 1'b1;
                     end
                  end
                  CMD_LOAD: begin
                     for (int i = 0; i < NUM_WORDS; i++)
                        words_d[i] = in_state_i[i*WORD_W +: WORD_W];
                  end
`ifdef STATE_BANK_ACCUM_EN
                  CMD_ACCUM: begin
                     // Per-word add. The carry out of each word is dropped.
                     for (int i = 0; i < NUM_WORDS; i++)
                        words_d[i] = words_q[i] + in_state_i[i*WORD_W +: WORD_W];
                  end
`endif
                  CMD_DUMP: begin
                     state_d     = S_DUMP;
                     idx_d       = '0;
                     dump_data_d = words_q[0];
                  end
                  default: ;  // HOLD, reserved codes, and ACCUM when disabled
               endcase
            end
         end
         S_DUMP: begin
            dump_valid_o = 1'b1;
            if (dump_ready_i) begin
               if (idx_last) begin
                  state_d     = S_IDLE;
                  idx_d       = '0;
                  dump_data_d = '0;
               end else begin
                  idx_d = idx_q + ADDR_W'(1);
                  for (int i = 0; i < NUM_WORDS; i++)
                     if (ADDR_W'(i) == idx_q + ADDR_W'(1)) dump_data_d = words_q[i];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
